// File: rtl/dm_arbiter.sv
// dm_arbiter
//   Shares one single-ported data memory between the pipeline MEM stage (CPU
//   port) and a DMA/debug loader port. Each access holds the memory bus for
//   MEM_LAT cycles and is followed by one DONE cycle. The CPU has fixed
//   priority, but the DMA wins after losing STARVE_MAX arbitrations in a row.
//   The pipeline stall is combinational; everything else is registered.

module dm_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  // CPU (MEM stage) port
  input  logic              cpu_re_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  // DMA / debug loader port
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  output logic              dma_gnt_o,
  output logic              dma_done_o,
  output logic [DATA_W-1:0] dma_rdata_o,
  // Data memory port
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUSY_CPU,
    S_BUSY_DMA,
    S_DONE_CPU,
    S_DONE_DMA
  } state_e;

  state_e            state_q;
  logic [LAT_W-1:0]  lat_cnt_q;
  logic [STV_W-1:0]  starve_cnt_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dma_rdata_q;
  logic              dma_gnt_q;
  logic              dma_done_q;
  // The mem_* registers double as the latched operation of the access in flight.
  logic              mem_re_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic cpu_req;
  logic dma_wins;
  logic lat_last;

  // Request decode and arbitration: CPU first unless DMA has been starved out.
  assign cpu_req  = cpu_re_i | cpu_we_i;
  assign dma_wins = dma_req_i & (~cpu_req | (starve_cnt_q == STV_MAX));
  assign lat_last = (lat_cnt_q == LAT_LAST);

  // The stall drops in DONE_CPU so the pipeline advances exactly once per access.
  assign cpu_stall_o = cpu_req & (state_q != S_DONE_CPU);

  assign cpu_rdata_o = cpu_rdata_q;
  assign dma_rdata_o = dma_rdata_q;
  assign dma_gnt_o   = dma_gnt_q;
  assign dma_done_o  = dma_done_q;
  assign mem_re_o    = mem_re_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  // Access sequencer: arbitrate in IDLE, hold the bus MEM_LAT cycles, one DONE cycle.
  // NOTE: every register here uses non-blocking assignment, so all branches see
  // the pre-edge values of state_q, lat_cnt_q and starve_cnt_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      dma_gnt_q    <= 1'b0;
      dma_done_q   <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      // Both DMA handshakes are single-cycle pulses unless re-armed below.
      dma_gnt_q  <= 1'b0;
      dma_done_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (!dma_req_i) starve_cnt_q <= '0;
          if (dma_wins) begin
            state_q      <= S_BUSY_DMA;
            starve_cnt_q <= '0;
            dma_gnt_q    <= 1'b1;
            lat_cnt_q    <= '0;
            mem_re_q     <= ~dma_we_i;
            mem_we_q     <= dma_we_i;
            mem_addr_q   <= dma_addr_i;
            mem_wdata_q  <= dma_wdata_i;
          end else if (cpu_req) begin
            state_q     <= S_BUSY_CPU;
            // Only reachable below STV_MAX, so the increment saturates by construction.
            if (dma_req_i) starve_cnt_q <= starve_cnt_q + 1'b1;
            lat_cnt_q   <= '0;
            // A simultaneous read and write request is serviced as a write.
            mem_re_q    <= ~cpu_we_i;
            mem_we_q    <= cpu_we_i;
            mem_addr_q  <= cpu_addr_i;
            mem_wdata_q <= cpu_wdata_i;
          end
        end

        S_BUSY_CPU, S_BUSY_DMA: begin
          if (lat_last) begin
            lat_cnt_q   <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if (state_q == S_BUSY_CPU) begin
              state_q <= S_DONE_CPU;
              if (mem_re_q) cpu_rdata_q <= mem_rdata_i;
            end else begin
              state_q    <= S_DONE_DMA;
              dma_done_q <= 1'b1;
              if (mem_re_q) dma_rdata_q <= mem_rdata_i;
            end
          end else begin
            lat_cnt_q <= lat_cnt_q + 1'b1;
          end
        end

        S_DONE_CPU, S_DONE_DMA: state_q <= S_IDLE;

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter
//   Directed scenarios followed by randomized CPU/DMA traffic with occasional
//   resets. A transaction-level reference model tracks when each access owns
//   the bus (as cycle windows) and what the memory holds, and every cycle the
//   DUT outputs are compared against it.

module tb_dm_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int L    = 2;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_re, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          dma_gnt, dma_done;
  logic          mem_re, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dm_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_re_i(cpu_re), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr),
    .dma_wdata_i(dma_wdata), .dma_gnt_o(dma_gnt), .dma_done_o(dma_done),
    .dma_rdata_o(dma_rdata),
    .mem_re_o(mem_re), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // Data memory seen by the DUT, and the model's own copy of what it should hold.
  logic [DW-1:0] dm      [0:65535];
  logic [DW-1:0] ref_mem [0:65535];
  assign mem_rdata = mem_re ? dm[mem_addr] : 16'hDEAD;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference model: the current access occupies bus cycles t_start..t_start+L-1,
  // completes in cycle t_start+L, and the next arbitration is at next_arb.
  int            t_start, next_arb, lost;
  bit            t_dma, t_we, prev_rst;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata, exp_cpu_rd, exp_dma_rd;

  // Requester agents.
  bit            cpu_pend, dma_pend, dma_w;
  int            cpu_op;               // 0 read, 1 write, 2 read+write
  int            cpu_pct, dma_pct;     // chance of a new request per free cycle
  logic [AW-1:0] cpu_a, dma_a;
  logic [DW-1:0] cpu_d, dma_d;

  // Observation counters for directed scenarios.
  int n_stall, n_mre, n_mwe, n_gnt, n_done, n_cpu_done;

  task automatic clear_counts();
    n_stall = 0; n_mre = 0; n_mwe = 0; n_gnt = 0; n_done = 0; n_cpu_done = 0;
  endtask

  task automatic model_reset();
    t_start = -1000; t_dma = 0; t_we = 0; t_addr = '0; t_wdata = '0;
    next_arb = cyc; lost = 0; exp_cpu_rd = '0; exp_dma_rd = '0;
  endtask

  // Advance one clock; apply the memory and model effects of the edge.
  task automatic tick();
    if (mem_we) dm[mem_addr] = mem_wdata;
    @(posedge clk);
    #1;
    cyc++;
    if (t_we && (cyc - 1 >= t_start) && (cyc - 1 <= t_start + L - 1))
      ref_mem[t_addr] = t_wdata;
    if (prev_rst) model_reset();
    else if (!t_we && (cyc - 1 == t_start + L - 1)) begin
      if (t_dma) exp_dma_rd = ref_mem[t_addr];
      else       exp_cpu_rd = ref_mem[t_addr];
    end
  endtask

  task automatic drive();
    if (!cpu_pend && cpu_pct > 0 && $urandom_range(99) < cpu_pct) begin
      cpu_pend = 1; cpu_op = $urandom_range(2);
      cpu_a = 16'(16'h0100 + $urandom_range(15)); cpu_d = 16'($urandom);
    end
    if (!dma_pend && dma_pct > 0 && $urandom_range(99) < dma_pct) begin
      dma_pend = 1; dma_w = 1'($urandom);
      dma_a = 16'(16'h0100 + $urandom_range(15)); dma_d = 16'($urandom);
    end
    cpu_re    = cpu_pend && (cpu_op != 1);
    cpu_we    = cpu_pend && (cpu_op != 0);
    cpu_addr  = cpu_pend ? cpu_a : 16'($urandom);
    cpu_wdata = cpu_pend ? cpu_d : 16'($urandom);
    dma_req   = dma_pend;
    dma_we    = dma_pend ? dma_w : 1'($urandom);
    dma_addr  = dma_pend ? dma_a : 16'($urandom);
    dma_wdata = dma_pend ? dma_d : 16'($urandom);
  endtask

  // Compare this cycle's outputs with the model, then arbitrate for the next one.
  task automatic eval();
    bit busy, done_k, creq;
    #1;
    busy   = (cyc >= t_start) && (cyc <= t_start + L - 1);
    done_k = (cyc == t_start + L);
    creq   = cpu_re | cpu_we;
    check("mem_re",    32'(mem_re),    32'(busy && !t_we));
    check("mem_we",    32'(mem_we),    32'(busy && t_we));
    check("mem_addr",  32'(mem_addr),  busy ? 32'(t_addr) : 32'd0);
    check("mem_wdata", 32'(mem_wdata), busy ? 32'(t_wdata) : 32'd0);
    check("dma_gnt",   32'(dma_gnt),   32'(t_dma && cyc == t_start));
    check("dma_done",  32'(dma_done),  32'(t_dma && done_k));
    check("cpu_stall", 32'(cpu_stall), 32'(creq && !(!t_dma && done_k)));
    check("cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu_rd));
    check("dma_rdata", 32'(dma_rdata), 32'(exp_dma_rd));
    if (cpu_stall) n_stall++;
    if (mem_re) n_mre++;
    if (mem_we) n_mwe++;
    if (dma_gnt) n_gnt++;
    if (dma_done) n_done++;
    if (creq && !cpu_stall) n_cpu_done++;
    if (done_k) begin
      if (t_dma) dma_pend = 0;
      else       cpu_pend = 0;
    end
    if (rst) prev_rst = 1;
    else begin
      prev_rst = 0;
      if (cyc >= next_arb) begin
        if (!dma_req) lost = 0;
        if (dma_req && (!creq || lost == SMAX)) begin
          lost = 0; t_dma = 1; t_we = dma_we; t_addr = dma_addr; t_wdata = dma_wdata;
          t_start = cyc + 1; next_arb = cyc + L + 2;
        end else if (creq) begin
          if (dma_req) lost++;
          t_dma = 0; t_we = cpu_we; t_addr = cpu_addr; t_wdata = cpu_wdata;
          t_start = cyc + 1; next_arb = cyc + L + 2;
        end
      end
    end
  endtask

  task automatic run_cycle(input bit r);
    tick();
    drive();
    rst = r;
    eval();
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60 && (cpu_pend || dma_pend); i++) run_cycle(0);
    check(tag, 32'(cpu_pend || dma_pend), 32'd0);
  endtask

  task automatic cpu_access(input int op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_op = op; cpu_a = a; cpu_d = d; cpu_pend = 1;
    clear_counts();
    wait_idle("cpu_timeout");
  endtask

  task automatic dma_access(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dma_w = w; dma_a = a; dma_d = d; dma_pend = 1;
    clear_counts();
    wait_idle("dma_timeout");
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      dm[i]      = 16'(i) ^ 16'hA5C3;
      ref_mem[i] = 16'(i) ^ 16'hA5C3;
    end
    dm[16'h0010] = 16'hBEEF; ref_mem[16'h0010] = 16'hBEEF;
    cpu_pend = 0; dma_pend = 0; cpu_pct = 0; dma_pct = 0;
    cpu_op = 0; dma_w = 0; cpu_a = '0; cpu_d = '0; dma_a = '0; dma_d = '0;
    rst = 1; cpu_re = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    clear_counts();

    // Two reset cycles with no requests: every output checked at zero.
    @(posedge clk);
    #1;
    model_reset();
    prev_rst = 0;
    eval();
    run_cycle(1);

    // Uncontended CPU read.
    cpu_access(0, 16'h0010, 16'h0000);
    check("t2_stall_cycles", 32'(n_stall), 32'(L + 1));
    check("t2_mem_re_cycles", 32'(n_mre), 32'(L));
    check("t2_rdata", 32'(cpu_rdata), 32'hBEEF);

    // DMA write, then the CPU reads it back.
    dma_access(1, 16'h0040, 16'h1234);
    check("t3_gnt_count", 32'(n_gnt), 32'd1);
    check("t3_done_count", 32'(n_done), 32'd1);
    check("t3_mem_we_cycles", 32'(n_mwe), 32'(L));
    cpu_access(0, 16'h0040, 16'h0000);
    check("t3_readback", 32'(cpu_rdata), 32'h1234);

    // Read and write together is a write only.
    cpu_access(2, 16'h0020, 16'h00FF);
    check("t5_mem_re_cycles", 32'(n_mre), 32'd0);
    check("t5_mem_we_cycles", 32'(n_mwe), 32'(L));
    check("t5_rdata_kept", 32'(cpu_rdata), 32'h1234);
    cpu_access(0, 16'h0020, 16'h0000);
    check("t5_readback", 32'(cpu_rdata), 32'h00FF);

    // Both ports requesting continuously: 4 CPU accesses per DMA access.
    cpu_pct = 100; dma_pct = 100;
    clear_counts();
    repeat (10 * (L + 2)) run_cycle(0);
    check("t4_cpu_accesses", 32'(n_cpu_done), 32'd8);
    check("t4_dma_grants", 32'(n_gnt), 32'd2);
    cpu_pct = 0; dma_pct = 0;
    wait_idle("t4_drain");

    // DMA read, then a DMA write aborted by reset in its last bus cycle.
    dma_access(0, 16'h0040, 16'h0000);
    check("t6_dma_read", 32'(dma_rdata), 32'h1234);
    dma_w = 1; dma_a = 16'h0050; dma_d = 16'h5555; dma_pend = 1;
    run_cycle(0);
    run_cycle(0);
    run_cycle(1);
    clear_counts();
    run_cycle(0);
    check("t6_mem_we_after_rst", 32'(mem_we), 32'd0);
    check("t6_no_done", 32'(dma_done), 32'd0);
    check("t6_dma_rdata_clr", 32'(dma_rdata), 32'd0);
    wait_idle("t6_reissue");
    check("t6_done_count", 32'(n_done), 32'd1);

    // Randomized traffic with occasional resets.
    for (int blk = 0; blk < 4; blk++) begin
      cpu_pct = $urandom_range(30, 95);
      dma_pct = $urandom_range(20, 95);
      for (int i = 0; i < 500; i++) run_cycle($urandom_range(249) == 0);
    end
    cpu_pct = 0; dma_pct = 0;
    wait_idle("final_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
